// File: rtl/spi_mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mult_pkg
//  Purpose  : Shared types and constants for the SPI multiply sequencer:
//             FSM state encoding, SPI frame width, default RX timeout.
//  Options  : SPI_MULT_SIGNED_EN (consumed by shift_add_mult)
//  Revision : 1.0  initial release
// ============================================================================
package spi_mult_pkg;

    localparam int FRAME_W        = 16;
    localparam int DEF_RX_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        MULT    = 3'd2,
        SEND_HI = 3'd3,
        WAIT_HI = 3'd4,
        SEND_LO = 3'd5,
        WAIT_LO = 3'd6
    } state_t;

endpackage : spi_mult_pkg
`default_nettype wire

// File: rtl/spi_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mult_sequencer_if
//  Purpose  : Frame-level link between the SPI block and the multiply
//             sequencer. 'master' is the SPI/host side, 'slave' is the
//             sequencer side.
//  Revision : 1.0  initial release
// ============================================================================
interface spi_mult_sequencer_if #(
    parameter int WIDTH = spi_mult_pkg::FRAME_W
);
    logic                 rx_valid;
    logic [WIDTH-1:0]     rx_data;
    logic                 tx_done;
    logic                 tx_start;
    logic [WIDTH-1:0]     tx_data;
    logic                 busy;
    logic [2*WIDTH-1:0]   result;
    logic                 result_valid;
    logic                 overrun;

    modport master (
        output rx_valid, rx_data, tx_done,
        input  tx_start, tx_data, busy, result, result_valid, overrun
    );

    modport slave (
        input  rx_valid, rx_data, tx_done,
        output tx_start, tx_data, busy, result, result_valid, overrun
    );
endinterface : spi_mult_sequencer_if
`default_nettype wire

// File: rtl/spi_mult_sequencer_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult
//  Purpose  : Radix-2 iterative shift-add multiplier. Operands are loaded on
//             'start', one multiplier bit is consumed per cycle for WIDTH
//             cycles, then 'done' pulses with 'product' valid.
//  Options  : SPI_MULT_SIGNED_EN - two's complement operands; magnitudes are
//             multiplied and one extra cycle conditionally negates.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult
    import spi_mult_pkg::*;
#(
    parameter int WIDTH = FRAME_W
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic              r_done;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;

`ifdef SPI_MULT_SIGNED_EN
    logic              r_neg;
    logic              r_fix;

    assign w_mag_a = op_a[WIDTH-1] ? ((~op_a) + WIDTH'(1)) : op_a;
    assign w_mag_b = op_b[WIDTH-1] ? ((~op_b) + WIDTH'(1)) : op_b;
`else
    assign w_mag_a = op_a;
    assign w_mag_b = op_b;
`endif

    // Load on start, then accumulate one partial product per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
`ifdef SPI_MULT_SIGNED_EN
            r_neg    <= 1'b0;
            r_fix    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_cnt    <= '0;
                r_run    <= 1'b1;
`ifdef SPI_MULT_SIGNED_EN
                r_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                r_fix    <= 1'b0;
`endif
            end else if (r_run) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (r_cnt == C_LAST) begin
                    r_run <= 1'b0;
`ifdef SPI_MULT_SIGNED_EN
                    r_fix <= 1'b1;
`else
                    r_done <= 1'b1;
`endif
                end
`ifdef SPI_MULT_SIGNED_EN
            end else if (r_fix) begin
                // Sign correction pass: magnitude product becomes signed
                r_fix  <= 1'b0;
                r_done <= 1'b1;
                if (r_neg) begin
                    r_acc <= (~r_acc) + PW'(1);
                end
`endif
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule : shift_add_mult
`default_nettype wire

// File: rtl/spi_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_mult_sequencer
//  Purpose  : Collects two operand frames from the SPI receive path,
//             multiplies them, and returns the 2*WIDTH product as two frames
//             (high half first) through the SPI transmit path.
//  Options  : SPI_MULT_SIGNED_EN - signed multiply (one extra MULT cycle)
//  Revision : 1.0  initial release
// ============================================================================
module spi_mult_sequencer
    import spi_mult_pkg::*;
#(
    parameter int WIDTH      = FRAME_W,
    parameter int RX_TIMEOUT = DEF_RX_TIMEOUT
)(
    input  logic                 clk,
    input  logic                 reset,
    spi_mult_sequencer_if.slave  bus
);

    localparam int TO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(RX_TIMEOUT - 1);
    localparam bit C_TO_EN = (RX_TIMEOUT != 0);

    state_t              r_state;
    logic [WIDTH-1:0]    r_op_a;
    logic [TO_W-1:0]     r_to;
    logic                r_tx_start;
    logic [WIDTH-1:0]    r_tx_data;
    logic                r_busy;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_result_valid;
    logic                r_overrun;

    logic                w_mult_start;
    logic                w_mult_done;
    logic [2*WIDTH-1:0]  w_product;
    logic                w_timeout;
    logic                w_rx_blocked;

    // Operand B goes straight from the receive bus into the multiplier so the
    // iterations begin on the edge after B is sampled.
    assign w_mult_start = (r_state == WAIT_B) && bus.rx_valid;
    assign w_timeout    = C_TO_EN && (r_to == C_TO_LAST);
    assign w_rx_blocked = bus.rx_valid && (r_state != IDLE) && (r_state != WAIT_B);

    shift_add_mult #(
        .WIDTH   (WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mult_start),
        .op_a    (r_op_a),
        .op_b    (bus.rx_data),
        .done    (w_mult_done),
        .product (w_product)
    );

    // Frame sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_op_a         <= '0;
            r_to           <= '0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_tx_start     <= 1'b0;
            r_result_valid <= 1'b0;

            // A frame arriving while one cannot be accepted is lost
            if (w_rx_blocked) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        r_op_a  <= bus.rx_data;
                        r_to    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A late B arriving on the timeout edge still wins
                    if (bus.rx_valid) begin
                        r_state <= MULT;
                    end else if (w_timeout) begin
                        r_op_a  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                MULT: begin
                    if (w_mult_done) begin
                        r_result       <= w_product;
                        r_result_valid <= 1'b1;
                        r_tx_start     <= 1'b1;
                        r_tx_data      <= w_product[2*WIDTH-1:WIDTH];
                        r_state        <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    r_state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.tx_done) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_result[WIDTH-1:0];
                        r_state    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    r_state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (bus.tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start     = r_tx_start;
    assign bus.tx_data      = r_tx_data;
    assign bus.busy         = r_busy;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.overrun      = r_overrun;

endmodule : spi_mult_sequencer
`default_nettype wire

// File: tb/tb_spi_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_mult_sequencer
//  Purpose  : Self-checking bench for spi_mult_sequencer. Stimulus pushes
//             expected products/frames into queues; a monitor pops and
//             compares whenever the DUT presents result_valid or tx_start.
//  Options  : SPI_MULT_SIGNED_EN selects signed expectations
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_mult_sequencer;

    localparam int W  = 16;
    localparam int TO = 40;
`ifdef SPI_MULT_SIGNED_EN
    localparam int LAT = W + 2;
    localparam logic [2*W-1:0] C_FF_PROD = 32'h0000_0001;
`else
    localparam int LAT = W + 1;
    localparam logic [2*W-1:0] C_FF_PROD = 32'hFFFE_0001;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_mult_sequencer_if #(.WIDTH(W)) bus();

    spi_mult_sequencer #(
        .WIDTH      (W),
        .RX_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [2*W-1:0] exp_result[$];
    logic [W-1:0]   exp_frame[$];
    logic [W-1:0]   held_tx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge
    initial begin
        held_tx = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                held_tx = '0;
            end else begin
                if (bus.result_valid) begin
                    if (exp_result.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_result_valid: result=0x%0h, none expected", bus.result);
                    end else begin
                        check("result", bus.result, exp_result.pop_front());
                    end
                end
                if (bus.tx_start) begin
                    if (exp_frame.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_tx_start: tx_data=0x%0h, none expected", bus.tx_data);
                    end else begin
                        check("tx_frame", bus.tx_data, exp_frame.pop_front());
                    end
                    held_tx = bus.tx_data;
                end else if (bus.tx_done || (bus.tx_data !== held_tx)) begin
                    check("tx_data_hold", bus.tx_data, held_tx);
                end
            end
        end
    end

    task automatic send_frame(input logic [W-1:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    task automatic wait_tx_start(output int n);
        n = 0;
        while (!bus.tx_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_start) begin
            n_vec++;
            n_bad++;
            $display("FAIL tx_start_timeout: none after %0d cycles, expected one", n);
        end
    endtask

    // mode 0: plain; 1: stray frame during MULT; 2: stray frame with final tx_done
    task automatic transact(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input int delay, input int mode);
        int n;
        int pre;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        hi = exp[2*W-1:W];
        lo = exp[W-1:0];
        exp_result.push_back(exp);
        exp_frame.push_back(hi);
        exp_frame.push_back(lo);
        send_frame(a);
        check("busy_after_a", bus.busy, 1);
        send_frame(b);
        pre = 0;
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            send_frame(16'hAAAA);
            pre = 4;
            check("overrun_in_mult", bus.overrun, 1);
        end
        wait_tx_start(n);
        check("first_tx_latency", pre + n, LAT);
        repeat (delay) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        wait_tx_start(n);
        check("second_tx_latency", n, 0);
        check("busy_wait_lo", bus.busy, 1);
        repeat (delay) @(negedge clk);
        bus.tx_done = 1'b1;
        if (mode == 2) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 16'hAAAA;
        end
        @(negedge clk);
        bus.tx_done  = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        check("busy_after_final_done", bus.busy, 0);
        check("result_held", bus.result, exp);
        if (mode == 2) begin
            check("overrun_coincident", bus.overrun, 1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_done  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_tx_start",     bus.tx_start,     0);
        check("rst_tx_data",      bus.tx_data,      0);
        check("rst_busy",         bus.busy,         0);
        check("rst_result",       bus.result,       0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_overrun",      bus.overrun,      0);

        transact(16'h0003, 16'h0005, 32'h0000_000F, 2, 0);
        transact(16'hFFFF, 16'hFFFF, C_FF_PROD, 3, 0);
        check("overrun_clean", bus.overrun, 0);

        // Operand A with no B: abandoned exactly on the TO-th edge in WAIT_B
        send_frame(16'h1234);
        repeat (TO - 1) @(negedge clk);
        check("busy_before_timeout", bus.busy, 1);
        @(negedge clk);
        check("busy_after_timeout", bus.busy, 0);
        repeat (5) @(negedge clk);
        transact(16'h0002, 16'h0004, 32'h0000_0008, 1, 0);
        check("overrun_after_timeout", bus.overrun, 0);

        transact(16'h0101, 16'h0003, 32'h0000_0303, 2, 1);

        // Reset mid-multiply: everything cleared, nothing emitted afterwards
        send_frame(16'h00FF);
        send_frame(16'h00FF);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",     bus.busy,     0);
        check("abort_tx_data",  bus.tx_data,  0);
        check("abort_result",   bus.result,   0);
        check("abort_overrun",  bus.overrun,  0);
        repeat (W + 10) @(negedge clk);
        check("abort_idle", bus.busy, 0);
        transact(16'h0010, 16'h0010, 32'h0000_0100, 2, 0);

        transact(16'h0005, 16'h0006, 32'h0000_001E, 2, 2);
        transact(16'h0007, 16'h0008, 32'h0000_0038, 1, 0);

        transact(16'h1234, 16'h0100, 32'h0012_3400, 40, 0);
        transact(16'h7BCD, 16'h0002, 32'h0000_F79A, 40, 0);

        repeat (5) @(negedge clk);
        check("leftover_results", exp_result.size(), 0);
        check("leftover_frames",  exp_frame.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_mult_sequencer
`default_nettype wire
